// File: rtl/swapcp_pkg.sv
// rtl/swapcp_pkg.sv - shared types and constants for the swap copy engine
package swapcp_pkg;

    localparam int LANE_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        MODE_PASS       = 2'd0,
        MODE_BYTE_REV   = 2'd1,
        MODE_HW_SWAP    = 2'd2,
        MODE_BYTE_IN_HW = 2'd3
    } mode_e;

endpackage

// File: rtl/swapcp_lane_swap.sv
// rtl/swapcp_lane_swap.sv - combinational byte/halfword swap of one 32-bit lane
module swapcp_lane_swap
    import swapcp_pkg::*;
(
    input  logic [1:0]        mode_i,
    input  logic [LANE_W-1:0] lane_i,
    output logic [LANE_W-1:0] lane_o
);

    // Select the lane rearrangement; byte 3 is the most significant byte
    always_comb begin
        lane_o = lane_i;
        case (mode_e'(mode_i))
            MODE_PASS:       lane_o = lane_i;
            MODE_BYTE_REV:   lane_o = {lane_i[7:0], lane_i[15:8], lane_i[23:16], lane_i[31:24]};
            MODE_HW_SWAP:    lane_o = {lane_i[15:0], lane_i[31:16]};
            MODE_BYTE_IN_HW: lane_o = {lane_i[23:16], lane_i[31:24], lane_i[7:0], lane_i[15:8]};
            default:         lane_o = lane_i;
        endcase
    end

endmodule

// File: rtl/lab5_swap_copy_engine.sv
// rtl/lab5_swap_copy_engine.sv - buffer-to-buffer copy with per-lane swap; SWAPCP_CHKSUM_EN adds XOR checksum
module lab5_swap_copy_engine
    import swapcp_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iStart,
    input  logic          iAbort,
    input  logic [1:0]    iMode,
    input  logic [AW:0]   iLen,
    input  logic [AW-1:0] iSrcBase,
    input  logic [AW-1:0] iDstBase,
    output logic          oBusy,
    output logic          oDone,
    output logic          oAborted,
    output logic [AW:0]   oWdCnt,
    output logic          oRdEn,
    output logic [AW-1:0] oRdAddr,
    input  logic [DW-1:0] iRdDt,
    output logic          oWrEn,
    output logic [AW-1:0] oWrAddr,
    output logic [DW-1:0] oWrDt,
    output logic [DW-1:0] oChkSum
);

    localparam int L = DW / LANE_W;
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW:0]   rd_idx_q, rd_idx_d;
    logic [AW:0]   wr_cnt_q, wr_cnt_d;
    logic          v1_q, v1_d;
    logic          v2_q, v2_d;
    logic [DW-1:0] dt_q, dt_d;
    logic          aborted_q, aborted_d;
    logic [DW-1:0] swapped;
    logic          abort_hit;
    logic          rd_en;
    logic          wr_en;

    for (genvar g = 0; g < L; g++) begin : g_lane
        swapcp_lane_swap u_swap (
            .mode_i (mode_q),
            .lane_i (iRdDt[g*LANE_W +: LANE_W]),
            .lane_o (swapped[g*LANE_W +: LANE_W])
        );
    end

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state, read issue and abort detection; abort suppresses this cycle's accesses
    always_comb begin
        state_d   = state_q;
        abort_hit = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iStart) state_d = ST_START;
            end
            ST_START: begin
                if (iAbort) begin
                    abort_hit = 1'b1;
                    state_d   = ST_DONE;
                end else if (len_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (iAbort) begin
                    abort_hit = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    rd_en = 1'b1;
                    if (rd_idx_q == len_q - CNT_ONE) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (iAbort) begin
                    abort_hit = 1'b1;
                    state_d   = ST_DONE;
                end else if (!v1_q && !v2_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign wr_en = v2_q && !abort_hit;

    // Parameter latch, indices and the two-stage read-to-write pipeline
    always_comb begin
        mode_d    = mode_q;
        len_d     = len_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rd_idx_d  = rd_idx_q;
        wr_cnt_d  = wr_cnt_q;
        aborted_d = aborted_q;
        v1_d      = rd_en;
        v2_d      = v1_q;
        dt_d      = v1_q ? swapped : dt_q;
        if (state_q == ST_IDLE && iStart) begin
            mode_d = iMode;
            len_d  = iLen;
            src_d  = iSrcBase;
            dst_d  = iDstBase;
        end
        if (state_q == ST_START) begin
            rd_idx_d  = '0;
            wr_cnt_d  = '0;
            aborted_d = 1'b0;
        end
        if (rd_en) rd_idx_d = rd_idx_q + CNT_ONE;
        if (wr_en) wr_cnt_d = wr_cnt_q + CNT_ONE;
        if (abort_hit) begin
            v1_d      = 1'b0;
            v2_d      = 1'b0;
            aborted_d = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            mode_q    <= '0;
            len_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            rd_idx_q  <= '0;
            wr_cnt_q  <= '0;
            aborted_q <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            dt_q      <= '0;
        end else begin
            mode_q    <= mode_d;
            len_q     <= len_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rd_idx_q  <= rd_idx_d;
            wr_cnt_q  <= wr_cnt_d;
            aborted_q <= aborted_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            dt_q      <= dt_d;
        end
    end

`ifdef SWAPCP_CHKSUM_EN
    logic [DW-1:0] chk_q, chk_d;

    // Running XOR of every word actually written, restarted for each copy
    always_comb begin
        chk_d = chk_q;
        if (state_q == ST_START) chk_d = '0;
        if (wr_en) chk_d = chk_q ^ dt_q;
    end

    // Checksum register
    always_ff @(posedge iClk) begin
        if (iRst) chk_q <= '0;
        else      chk_q <= chk_d;
    end

    assign oChkSum = chk_q;
`else
    assign oChkSum = '0;
`endif

    assign oBusy    = (state_q != ST_IDLE);
    assign oDone    = (state_q == ST_DONE);
    assign oAborted = aborted_q;
    assign oWdCnt   = wr_cnt_q;
    assign oRdEn    = rd_en;
    assign oRdAddr  = src_q + rd_idx_q[AW-1:0];
    assign oWrEn    = wr_en;
    assign oWrAddr  = dst_q + wr_cnt_q[AW-1:0];
    assign oWrDt    = dt_q;

endmodule

// File: tb/tb_lab5_swap_copy_engine.sv
// tb/tb_lab5_swap_copy_engine.sv - directed self-checking bench for lab5_swap_copy_engine (DW=64)
module tb_lab5_swap_copy_engine;

    localparam int DW = 64;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          iRst, iStart, iAbort;
    logic [1:0]    iMode;
    logic [AW:0]   iLen;
    logic [AW-1:0] iSrcBase, iDstBase;
    logic          oBusy, oDone, oAborted, oRdEn, oWrEn;
    logic [AW:0]   oWdCnt;
    logic [AW-1:0] oRdAddr, oWrAddr;
    logic [DW-1:0] iRdDt, oWrDt, oChkSum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0;

    logic [DW-1:0] src_mem [512];

    logic [AW-1:0] rd_addr_q [$];
    int            rd_cyc_q  [$];
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_dt_q   [$];
    int            wr_cyc_q  [$];
    int            done_n;
    int            done_cyc;
    logic          done_ab;
    logic [AW:0]   done_cnt;
    logic [DW-1:0] done_chk;
    logic [DW-1:0] exp_chk;

    lab5_swap_copy_engine #(.DW(DW), .AW(AW)) dut (
        .iClk     (clk),
        .iRst     (iRst),
        .iStart   (iStart),
        .iAbort   (iAbort),
        .iMode    (iMode),
        .iLen     (iLen),
        .iSrcBase (iSrcBase),
        .iDstBase (iDstBase),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oAborted (oAborted),
        .oWdCnt   (oWdCnt),
        .oRdEn    (oRdEn),
        .oRdAddr  (oRdAddr),
        .iRdDt    (iRdDt),
        .oWrEn    (oWrEn),
        .oWrAddr  (oWrAddr),
        .oWrDt    (oWrDt),
        .oChkSum  (oChkSum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (oRdEn === 1'b1) iRdDt <= src_mem[oRdAddr];
    end

    always @(negedge clk) begin
        if (oRdEn === 1'b1) begin
            rd_addr_q.push_back(oRdAddr);
            rd_cyc_q.push_back(cyc);
        end
        if (oWrEn === 1'b1) begin
            wr_addr_q.push_back(oWrAddr);
            wr_dt_q.push_back(oWrDt);
            wr_cyc_q.push_back(cyc);
        end
        if (oDone === 1'b1) begin
            done_n   = done_n + 1;
            done_cyc = cyc;
            done_ab  = oAborted;
            done_cnt = oWdCnt;
            done_chk = oChkSum;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        wr_addr_q.delete();
        wr_dt_q.delete();
        wr_cyc_q.delete();
        done_n = 0;
    endtask

    task automatic start(input logic [1:0] m, input logic [AW:0] n,
                         input logic [AW-1:0] s, input logic [AW-1:0] d);
        clear_log();
        iMode    = m;
        iLen     = n;
        iSrcBase = s;
        iDstBase = d;
        iStart   = 1'b1;
        t0       = cyc;
        @(posedge clk); #1;
        iStart   = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (done_n == 0 && k < limit) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_seen", done_n != 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) src_mem[i] = 64'(i);
        src_mem[0]     = 64'h11223344_55667788;
        src_mem[1]     = 64'h99AABBCC_DDEEFF00;
        src_mem[2]     = 64'h01020304_05060708;
        src_mem[3]     = 64'hA1B2C3D4_E5F60718;
        src_mem[9'h20] = 64'hAAAABBBB_CCCCDDDD;
        src_mem[9'h21] = 64'h11223344_55667788;
        src_mem[9'h30] = 64'd1;
        src_mem[9'h31] = 64'd2;
        src_mem[9'h32] = 64'd4;
        src_mem[9'h1FE] = 64'hFE00FE00_FE00FE00;
        src_mem[9'h1FF] = 64'hFF11FF11_FF11FF11;
`ifdef SWAPCP_CHKSUM_EN
        exp_chk = 64'd7;
`else
        exp_chk = 64'd0;
`endif
        iRst = 1'b1; iStart = 1'b0; iAbort = 1'b0; iMode = '0; iLen = '0;
        iSrcBase = '0; iDstBase = '0; iRdDt = '0;
        done_n = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", oBusy, 0);
        check("rst_done", oDone, 0);
        check("rst_aborted", oAborted, 0);
        check("rst_wdcnt", oWdCnt, 0);
        check("rst_rden", oRdEn, 0);
        check("rst_rdaddr", oRdAddr, 0);
        check("rst_wren", oWrEn, 0);
        check("rst_wraddr", oWrAddr, 0);
        check("rst_wrdt", oWrDt, 0);
        check("rst_chksum", oChkSum, 0);
        iRst = 1'b0;
        @(posedge clk); #1;

        // mode 1 full byte reverse, N=4, src 0 -> dst 0x10
        start(2'd1, 10'd4, 9'h000, 9'h010);
        wait_done(50);
        check("m1_nwr", wr_addr_q.size(), 4);
        check("m1_nrd", rd_addr_q.size(), 4);
        check("m1_first_rd_cyc", rd_cyc_q[0], t0 + 2);
        check("m1_first_wr_cyc", wr_cyc_q[0], t0 + 4);
        check("m1_wr3_cyc", wr_cyc_q[3], t0 + 7);
        check("m1_done_cyc", done_cyc, t0 + 9);
        check("m1_wdcnt", done_cnt, 4);
        check("m1_aborted", done_ab, 0);
        check("m1_wa0", wr_addr_q[0], 9'h010);
        check("m1_wa3", wr_addr_q[3], 9'h013);
        check("m1_wd0", wr_dt_q[0], 64'h44332211_88776655);
        check("m1_wd1", wr_dt_q[1], 64'hCCBBAA99_00FFEEDD);
        check("m1_wd2", wr_dt_q[2], 64'h04030201_08070605);
        check("m1_wd3", wr_dt_q[3], 64'hD4C3B2A1_1807F6E5);
        check("m1_busy_after", oBusy, 0);
        check("m1_done_pulses", done_n, 1);

        // mode 2 halfword swap
        start(2'd2, 10'd1, 9'h020, 9'h080);
        wait_done(50);
        check("m2_wd", wr_dt_q[0], 64'hBBBBAAAA_DDDDCCCC);
        check("m2_wa", wr_addr_q[0], 9'h080);
        check("m2_done_cyc", done_cyc, t0 + 6);

        // mode 3 bytes swapped within halfwords
        start(2'd3, 10'd1, 9'h021, 9'h081);
        wait_done(50);
        check("m3_wd", wr_dt_q[0], 64'h22114433_66558877);

        // mode 0 pass-through with checksum 1^2^4
        start(2'd0, 10'd3, 9'h030, 9'h040);
        wait_done(50);
        check("m0_wd2", wr_dt_q[2], 64'd4);
        check("m0_chksum", done_chk, exp_chk);
        check("m0_done_cyc", done_cyc, t0 + 8);

        // address wrap at 2^AW
        start(2'd0, 10'd3, 9'h1FE, 9'h1FF);
        wait_done(50);
        check("wrap_ra0", rd_addr_q[0], 9'h1FE);
        check("wrap_ra1", rd_addr_q[1], 9'h1FF);
        check("wrap_ra2", rd_addr_q[2], 9'h000);
        check("wrap_wa0", wr_addr_q[0], 9'h1FF);
        check("wrap_wa1", wr_addr_q[1], 9'h000);
        check("wrap_wa2", wr_addr_q[2], 9'h001);
        check("wrap_wd2", wr_dt_q[2], 64'h11223344_55667788);

        // max-length copy aborted after the 10th write; a mid-run iStart is ignored
        start(2'd0, 10'd512, 9'h000, 9'h100);
        for (int k = 0; k < 100; k++) begin
            iStart = (cyc == t0 + 6);
            if (cyc == t0 + 6) begin
                iLen     = 10'd1;
                iDstBase = 9'h055;
            end
            if (wr_addr_q.size() >= 10) begin
                iAbort = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        iStart = 1'b0;
        @(posedge clk); #1;
        iAbort = 1'b0;
        wait_done(50);
        check("ab_nwr", wr_addr_q.size(), 10);
        check("ab_last_wa", wr_addr_q[9], 9'h109);
        check("ab_aborted", done_ab, 1);
        check("ab_wdcnt", done_cnt, 10);
        check("ab_done_cyc", done_cyc, t0 + 15);
        @(posedge clk); #1;
        check("ab_held", oAborted, 1);
        check("ab_no_late_wr", wr_addr_q.size(), 10);

        // zero length, with iAbort in the same IDLE cycle as iStart
        iAbort = 1'b1;
        start(2'd1, 10'd0, 9'h000, 9'h000);
        iAbort = 1'b0;
        wait_done(50);
        check("z_nrd", rd_addr_q.size(), 0);
        check("z_nwr", wr_addr_q.size(), 0);
        check("z_done_cyc", done_cyc, t0 + 2);
        check("z_wdcnt", done_cnt, 0);
        check("z_aborted", done_ab, 0);

        // reset in the middle of a copy
        start(2'd0, 10'd20, 9'h000, 9'h000);
        repeat (4) @(posedge clk);
        #1;
        iRst = 1'b1;
        @(posedge clk); #1;
        iRst = 1'b0;
        clear_log();
        check("mr_busy", oBusy, 0);
        repeat (6) @(posedge clk);
        #1;
        check("mr_nrd", rd_addr_q.size(), 0);
        check("mr_nwr", wr_addr_q.size(), 0);
        check("mr_ndone", done_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
